// File: rtl/circular_buff_param.sv
// rtl/circular_buff_param.sv - parametrised single-clock FIFO; sticky OVERFLOW/UNDERFLOW enabled by CIRC_BUFF_ERR_FLAGS_EN
module circular_buff_param #(
   parameter int DATAWIDTH     = 8,
   parameter int BUFFSIZE      = 8,
   parameter int PTRSIZE       = 3,
   parameter int AFULL_THRESH  = 6,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 WRITE,
   input  logic [DATAWIDTH-1:0] WRDATA,
   input  logic                 READ,
   output logic [DATAWIDTH-1:0] RDDATA,
   output logic                 RDVALID,
   output logic [PTRSIZE:0]     COUNT,
   output logic                 ISFULL,
   output logic                 ISEMPTY,
   output logic                 ALMOSTFULL,
   output logic                 ALMOSTEMPTY,
   output logic                 OVERFLOW,
   output logic                 UNDERFLOW,
   input  logic                 CLR_ERR
);

   localparam int CW = PTRSIZE + 1;
   localparam logic [PTRSIZE:0]   DEPTH_C  = CW'(BUFFSIZE);
   localparam logic [PTRSIZE:0]   AFULL_C  = CW'(AFULL_THRESH);
   localparam logic [PTRSIZE:0]   AEMPTY_C = CW'(AEMPTY_THRESH);
   localparam logic [PTRSIZE-1:0] LAST_C   = PTRSIZE'(BUFFSIZE - 1);

   logic [DATAWIDTH-1:0] mem_q [BUFFSIZE];

   logic [PTRSIZE-1:0]   wrptr_q, wrptr_d;
   logic [PTRSIZE-1:0]   rdptr_q, rdptr_d;
   logic [PTRSIZE:0]     count_q, count_d;
   logic [DATAWIDTH-1:0] rddata_q, rddata_d;
   logic                 rdvalid_q, rdvalid_d;
   logic                 wr_ok, rd_ok;
   logic                 is_full, is_empty;

   // Status flags are pure decodes of the registered occupancy
   assign is_full     = (count_q == DEPTH_C);
   assign is_empty    = (count_q == '0);
   assign COUNT       = count_q;
   assign ISFULL      = is_full;
   assign ISEMPTY     = is_empty;
   assign ALMOSTFULL  = (count_q >= AFULL_C);
   assign ALMOSTEMPTY = (count_q <= AEMPTY_C);
   assign RDDATA      = rddata_q;
   assign RDVALID     = rdvalid_q;

   // Acceptance, pointer wrap at BUFFSIZE-1, occupancy and read-data next state
   always_comb begin
      rd_ok     = READ && !is_empty;
      wr_ok     = WRITE && (!is_full || rd_ok);
      wrptr_d   = wrptr_q;
      rdptr_d   = rdptr_q;
      count_d   = count_q;
      rddata_d  = rddata_q;
      rdvalid_d = rd_ok;
      if (wr_ok) begin
         wrptr_d = (wrptr_q == LAST_C) ? '0 : wrptr_q + 1'b1;
      end
      if (rd_ok) begin
         rdptr_d  = (rdptr_q == LAST_C) ? '0 : rdptr_q + 1'b1;
         rddata_d = mem_q[rdptr_q];
      end
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state register with asynchronous clear
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wrptr_q   <= '0;
         rdptr_q   <= '0;
         count_q   <= '0;
         rddata_q  <= '0;
         rdvalid_q <= 1'b0;
      end else begin
         wrptr_q   <= wrptr_d;
         rdptr_q   <= rdptr_d;
         count_q   <= count_d;
         rddata_q  <= rddata_d;
         rdvalid_q <= rdvalid_d;
      end
   end

   // Storage array is deliberately left uncleared by reset
   always_ff @(posedge CLK) begin
      if (wr_ok) begin
         mem_q[wrptr_q] <= WRDATA;
      end
   end

`ifdef CIRC_BUFF_ERR_FLAGS_EN
   logic ovf_q, ovf_d, udf_q, udf_d;

   // Sticky error flags; a set condition overrides a simultaneous clear
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (CLR_ERR) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (WRITE && is_full && !READ) ovf_d = 1'b1;
      if (READ && is_empty)          udf_d = 1'b1;
   end

   // Error flag registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign OVERFLOW  = ovf_q;
   assign UNDERFLOW = udf_q;
`else
   logic unused_clr_err;
   assign unused_clr_err = CLR_ERR;
   assign OVERFLOW       = 1'b0;
   assign UNDERFLOW      = 1'b0;
`endif

endmodule

// File: tb/tb_circular_buff_param.sv
// tb/tb_circular_buff_param.sv - scoreboard bench for circular_buff_param at depth 8 and depth 5
module tb_circular_buff_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr = 1'b0, rd = 1'b0, clr = 1'b0;
   logic [7:0] wdata = '0;

   logic [7:0] rddata  [2];
   logic       rdvalid [2];
   logic [3:0] count   [2];
   logic       isfull  [2];
   logic       isempty [2];
   logic       afull   [2];
   logic       aempty  [2];
   logic       ovf     [2];
   logic       udf     [2];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: contents as a queue, reads awaiting output, last output word
   logic [7:0] fifo_m [2][$];
   logic [7:0] exp_rd [2][$];
   logic [7:0] last_rd [2];
   logic       exp_ovf [2];
   logic       exp_udf [2];

   always #5 clk = ~clk;

   circular_buff_param u_dut8 (
      .CLK(clk), .RST_N(rst_n), .WRITE(wr), .WRDATA(wdata), .READ(rd),
      .RDDATA(rddata[0]), .RDVALID(rdvalid[0]), .COUNT(count[0]),
      .ISFULL(isfull[0]), .ISEMPTY(isempty[0]), .ALMOSTFULL(afull[0]),
      .ALMOSTEMPTY(aempty[0]), .OVERFLOW(ovf[0]), .UNDERFLOW(udf[0]),
      .CLR_ERR(clr)
   );

   circular_buff_param #(
      .DATAWIDTH(8), .BUFFSIZE(5), .PTRSIZE(3), .AFULL_THRESH(4), .AEMPTY_THRESH(1)
   ) u_dut5 (
      .CLK(clk), .RST_N(rst_n), .WRITE(wr), .WRDATA(wdata), .READ(rd),
      .RDDATA(rddata[1]), .RDVALID(rdvalid[1]), .COUNT(count[1]),
      .ISFULL(isfull[1]), .ISEMPTY(isempty[1]), .ALMOSTFULL(afull[1]),
      .ALMOSTEMPTY(aempty[1]), .OVERFLOW(ovf[1]), .UNDERFLOW(udf[1]),
      .CLR_ERR(clr)
   );

   function automatic int depth_of(input int i);
      return (i == 0) ? 8 : 5;
   endfunction

   function automatic int afull_of(input int i);
      return (i == 0) ? 6 : 4;
   endfunction

   function automatic int aempty_of(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[dut%0d] t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
      end
   endtask

   // Apply one cycle of stimulus and advance the model by the rules of the FIFO
   task automatic drive(input logic w, input logic r, input logic [7:0] d, input logic c);
      int  sz;
      bit  rok, wok;
      @(negedge clk);
      #2;
      wr = w; rd = r; wdata = d; clr = c;
      for (int i = 0; i < 2; i++) begin
         sz  = fifo_m[i].size();
         rok = r && (sz > 0);
         wok = w && ((sz < depth_of(i)) || rok);
`ifdef CIRC_BUFF_ERR_FLAGS_EN
         if (w && sz == depth_of(i) && !r) exp_ovf[i] = 1'b1;
         else if (c)                       exp_ovf[i] = 1'b0;
         if (r && sz == 0)                 exp_udf[i] = 1'b1;
         else if (c)                       exp_udf[i] = 1'b0;
`endif
         if (rok) exp_rd[i].push_back(fifo_m[i].pop_front());
         if (wok) fifo_m[i].push_back(d);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 2; i++) begin
         fifo_m[i].delete();
         exp_rd[i].delete();
         last_rd[i] = 8'h00;
         exp_ovf[i] = 1'b0;
         exp_udf[i] = 1'b0;
      end
   endtask

   // Asynchronous reset: outputs must clear before any clock edge
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      wr = 1'b0; rd = 1'b0; clr = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_count",   i, 32'(count[i]),   32'd0);
         chk("rst_isempty", i, 32'(isempty[i]), 32'd1);
         chk("rst_rdvalid", i, 32'(rdvalid[i]), 32'd0);
         chk("rst_ovf",     i, 32'(ovf[i]),     32'd0);
         chk("rst_udf",     i, 32'(udf[i]),     32'd0);
      end
      clear_model();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Monitor: pop expected read data whenever the DUT presents RDVALID; check status each cycle
   logic [7:0] mon_e;
   int         mon_n;
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            chk("rdvalid", i, 32'(rdvalid[i]), 32'(exp_rd[i].size() > 0));
            if (exp_rd[i].size() > 0) begin
               mon_e = exp_rd[i].pop_front();
               if (rdvalid[i]) chk("rddata", i, 32'(rddata[i]), 32'(mon_e));
               last_rd[i] = mon_e;
            end else begin
               chk("rddata_hold", i, 32'(rddata[i]), 32'(last_rd[i]));
            end
            mon_n = fifo_m[i].size();
            chk("count",       i, 32'(count[i]),   32'(mon_n));
            chk("count_max",   i, 32'(count[i] <= 4'(depth_of(i))), 32'd1);
            chk("isfull",      i, 32'(isfull[i]),  32'(mon_n == depth_of(i)));
            chk("isempty",     i, 32'(isempty[i]), 32'(mon_n == 0));
            chk("almostfull",  i, 32'(afull[i]),   32'(mon_n >= afull_of(i)));
            chk("almostempty", i, 32'(aempty[i]),  32'(mon_n <= aempty_of(i)));
            chk("overflow",    i, 32'(ovf[i]),     32'(exp_ovf[i]));
            chk("underflow",   i, 32'(udf[i]),     32'(exp_udf[i]));
         end
      end
   end

   int pw, pr;

   initial begin
      clear_model();
      do_reset();

      // Fill with 0x11..0x18, then full read+write, then drain
      for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 8'(8'h11 + k), 1'b0);
      drive(1'b1, 1'b1, 8'hAA, 1'b0);
      for (int k = 0; k < 9; k++) drive(1'b0, 1'b1, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);

      // Empty with simultaneous read+write: write only, then read it back
      drive(1'b1, 1'b1, 8'h55, 1'b0);
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);

      // Error flags: overfill, over-read, clear
      for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 8'(8'h30 + k), 1'b0);
      drive(1'b1, 1'b0, 8'h99, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 9; k++) drive(1'b0, 1'b1, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b1, 8'h00, 1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b0);

      // Randomised traffic: write-heavy then read-heavy
      for (int k = 0; k < 400; k++) begin
         pw = (k < 200) ? 65 : 35;
         pr = (k < 200) ? 40 : 65;
         drive(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
               8'($urandom), ($urandom_range(0, 19) == 0));
      end
      for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, 8'h00, 1'b0);

      // Reset mid-burst at COUNT=4 with a read in flight
      do_reset();
      for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 8'(8'hC0 + k), 1'b0);
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      do_reset();
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/circular_buff_param.md
Name: circular_buff_param

Overview:
- Parametrised successor to the team's fixed 8x8 circular buffer: single-clock FIFO, arbitrary depth (power of two not required), configurable width.
- Adds occupancy count, almost-full/almost-empty thresholds, registered read data with a valid strobe, and defined simultaneous read/write semantics at full and empty.
- Storage is an internal register array; no external memory instance.
- Sits between producer and consumer datapaths in the same clock domain.

Parameters:
- DATAWIDTH, 8, data word width in bits (>=1)
- BUFFSIZE, 8, depth in words (>=2; any integer)
- PTRSIZE, 3, pointer width; must equal ceil(log2(BUFFSIZE))
- AFULL_THRESH, 6, ALMOSTFULL asserts when COUNT >= AFULL_THRESH (1..BUFFSIZE)
- AEMPTY_THRESH, 2, ALMOSTEMPTY asserts when COUNT <= AEMPTY_THRESH (0..BUFFSIZE-1)

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous, active-low reset
- WRITE  input  1  write request
- WRDATA  input  DATAWIDTH  write data
- READ  input  1  read request
- RDDATA  output  DATAWIDTH  registered read data
- RDVALID  output  1  RDDATA holds a newly read word this cycle
- COUNT  output  PTRSIZE+1  words currently stored
- ISFULL  output  1  COUNT == BUFFSIZE
- ISEMPTY  output  1  COUNT == 0
- ALMOSTFULL  output  1  COUNT >= AFULL_THRESH
- ALMOSTEMPTY  output  1  COUNT <= AEMPTY_THRESH
- OVERFLOW  output  1  sticky error flag (see Optional Feature)
- UNDERFLOW  output  1  sticky error flag (see Optional Feature)
- CLR_ERR  input  1  synchronous clear of OVERFLOW/UNDERFLOW

Behaviour:
- Reset (RST_N low, asynchronous assert; deassertion takes effect at the next CLK edge):
  - wrptr, rdptr, COUNT, RDDATA, RDVALID, OVERFLOW and UNDERFLOW all go to 0.
  - ISEMPTY=1, ISFULL=0, ALMOSTEMPTY=1; ALMOSTFULL=0.
  - Storage array is not cleared.
  - Reset mid-operation discards all contents and any in-flight RDVALID immediately.
- Write acceptance: wr_ok = WRITE && (!ISFULL || rd_ok). Data is stored at wrptr on the edge; wrptr advances.
- Read acceptance: rd_ok = READ && !ISEMPTY. No bypass: a read on empty is rejected even if a write occurs in the same cycle.
- Pointer wrap: a pointer at BUFFSIZE-1 advances to 0. Depth need not be a power of two.
- COUNT update per edge:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - unchanged when both or neither are accepted.
  - Never exceeds BUFFSIZE and never underflows.
- Simultaneous events:
  - Full + READ + WRITE: both accepted; COUNT stays BUFFSIZE. The read returns the oldest word, not the new one.
  - Empty + READ + WRITE: write only; COUNT becomes 1.
- Read latency:
  - rd_ok at edge N gives RDDATA = mem[rdptr] and RDVALID=1 after edge N, for exactly one cycle per accepted read.
  - Back-to-back reads give RDVALID high on consecutive cycles.
  - RDDATA holds its last value while RDVALID=0.
- Write-to-read latency: a word written at edge N makes ISEMPTY=0 after edge N. It can be read at edge N+1, with data out after N+1.
- Flag timing: all status flags decode combinationally from the registered COUNT, so they update in the same cycle COUNT changes.
- Order: strict FIFO; no data loss while within capacity.

Optional Feature:
- Macro: CIRC_BUFF_ERR_FLAGS_EN
- Defined:
  - OVERFLOW sets on WRITE && ISFULL && !READ (rejected write).
  - UNDERFLOW sets on READ && ISEMPTY (rejected read).
  - Both flags are sticky until CLR_ERR=1 at a CLK edge or reset.
  - If CLR_ERR and a set condition occur in the same cycle, the set condition wins.
- Undefined:
  - OVERFLOW and UNDERFLOW are tied to 0 and CLR_ERR is ignored.
  - Rejected operations are silently dropped.
  - All other behaviour is identical.

Test Plan:
- Reset, then write 0x11..0x18 (8 writes, defaults) -> ISFULL=1, COUNT=8, ALMOSTFULL high from COUNT=6. Then 8 reads -> RDDATA 0x11..0x18 in order, RDVALID one cycle after each read, ISEMPTY=1.
- Full, READ+WRITE 0xAA same cycle -> COUNT stays 8, RDDATA=oldest word. After 8 further reads, 0xAA is the last word out.
- Empty, READ+WRITE 0x55 same cycle -> RDVALID=0, COUNT=1. Next-cycle read -> RDDATA=0x55.
- BUFFSIZE=5, PTRSIZE=3: stream 20 words with interleaved reads -> wrap-around ordering preserved, COUNT never above 5.
- Macro on: write when full -> OVERFLOW=1 and data dropped; read when empty -> UNDERFLOW=1; CLR_ERR pulse -> both 0.
- Drop RST_N mid-burst at COUNT=4 -> COUNT=0, ISEMPTY=1 and RDVALID=0 immediately, without waiting for a CLK edge.
